button_debounce_pulse: RTL

Input-conditioning stage between a raw, bouncing push-button pin and the LED toggle logic. Synchronises the pin, debounces it with a counter-based state machine, and produces a clean level plus single-cycle press, release and long-press strobes. The strobes are in the `clk` domain, so downstream logic samples them synchronously instead of clocking on a derived edge.

---
 rtl/button_debounce_pulse.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - synchronised, debounced push-button with press/release/long-press strobes
module button_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_p,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  // Last count value before a transition is accepted; the entry sample counts as the first.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] L_PRE  = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic          RAW_IDLE = ~ACTIVE_HIGH;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state;
  logic            sync_1;
  logic            sync_2;
  logic            act;
  logic [DW-1:0]   dcnt;
  logic [LW-1:0]   lcnt;
  logic            lfired;
  logic            rel_confirm;
  logic            long_hit;

  // Two-flop synchroniser on the raw pin, parked at the not-pressed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= RAW_IDLE;
      sync_2 <= RAW_IDLE;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
    end
  end

  assign act = sync_2 ~^ ACTIVE_HIGH;

  // Release confirmation takes priority over the long-press threshold on the same edge.
  always_comb begin
    rel_confirm = 1'b0;
    long_hit    = 1'b0;
    if (state == RELEASE_WAIT && !act && dcnt == D_LAST) begin
      rel_confirm = 1'b1;
    end
    if ((state == HELD || state == RELEASE_WAIT) && lcnt == L_PRE && !lfired && !rel_confirm) begin
      long_hit = 1'b1;
    end
  end

  // Debounce FSM with registered level and single-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dcnt       <= '0;
      lcnt       <= '0;
      lfired     <= 1'b0;
      level      <= 1'b0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;

      case (state)
        IDLE: begin
          if (act) begin
            state <= PRESS_WAIT;
            dcnt  <= D_ONE;
          end
        end

        PRESS_WAIT: begin
          if (!act) begin
            state <= IDLE;
            dcnt  <= '0;
          end else if (dcnt == D_LAST) begin
            state  <= HELD;
            dcnt   <= '0;
            level  <= 1'b1;
            press  <= 1'b1;
            lcnt   <= L_ONE;
            lfired <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        HELD: begin
          if (lcnt != L_MAX) begin
            lcnt <= lcnt + 1'b1;
          end
          if (!act) begin
            state <= RELEASE_WAIT;
            dcnt  <= D_ONE;
          end
        end

        RELEASE_WAIT: begin
          if (rel_confirm) begin
            state     <= IDLE;
            dcnt      <= '0;
            lcnt      <= '0;
            level     <= 1'b0;
            release_p <= 1'b1;
          end else begin
            if (lcnt != L_MAX) begin
              lcnt <= lcnt + 1'b1;
            end
            if (act) begin
              state <= HELD;
              dcnt  <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          dcnt  <= '0;
        end
      endcase

      if (long_hit) begin
        long_press <= 1'b1;
        lfired     <= 1'b1;
      end
    end
  end

endmodule
